// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the run-time programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned DIV_MIN = 2;

  // A ratio is legal when it is at least DIV_MIN and either even or odd
  // ratios are enabled. The upper bound 2^DIV_W-1 is implied by the port width.
  function automatic logic div_legal(input logic [31:0] n, input logic odd_en);
    return (n >= DIV_MIN) && (odd_en || !n[0]);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter for the divider: tracks position within the current period,
// flags the boundary cycle and produces the registered clko / tick outputs.
// High phase is n>>1 cycles, low phase is the remainder.
module clk_div_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] n,
  input  logic             run,
  input  logic             start,
  output logic             boundary,
  output logic             clko,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] hi;

  assign hi       = n >> 1;
  assign cnt_inc  = cnt + 1'b1;
  assign boundary = (cnt == n - 1'b1);

  // Period counter: start a new period, advance within one, or park at zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register here sees pre-edge values.
    if (rst) begin
      cnt  <= '0;
      clko <= 1'b0;
      tick <= 1'b0;
    end else if (start) begin
      cnt  <= '0;
      clko <= 1'b1;
      tick <= 1'b1;
    end else if (run && !boundary) begin
      cnt  <= cnt_inc;
      tick <= 1'b0;
      if (cnt_inc == hi) clko <= 1'b0;
    end else begin
      cnt  <= '0;
      clko <= 1'b0;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time reconfigurable clock divider controller.
// Holds the STOP/RUN/DRAIN FSM, the pending-ratio register and the
// valid/ready configuration handshake; the period counter lives in clk_div_core.
// Optional feature macro: CLK_DIV_ODD_EN (accept odd divide ratios).
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clko,
  output logic             tick,
  output logic             busy
);

`ifdef CLK_DIV_ODD_EN
  localparam logic ODD_EN = 1'b1;
`else
  localparam logic ODD_EN = 1'b0;
`endif

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  logic             pend;
  logic             xfer;
  logic             legal;
  logic             boundary;
  logic             period_end;
  logic             core_run;
  logic             core_start;

  assign xfer       = cfg_valid & cfg_ready;
  assign legal      = div_legal(32'(cfg_div), ODD_EN);
  assign cfg_ready  = ~pend;
  assign period_end = busy & boundary;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STOP;
    else     state <= state_next;
  end

  // Next state: a running period always completes; en at the boundary
  // decides whether another period follows or the divider stops.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_next = state;
    case (state)
      STOP:       if (en) state_next = RUN;
      RUN, DRAIN: begin
        if (boundary) state_next = en ? RUN : STOP;
        else          state_next = en ? RUN : DRAIN;
      end
      default:    state_next = STOP;
    endcase
  end

  // Outputs of the FSM: busy flag and the controls for the period counter.
  always_comb begin
    busy       = (state != STOP);
    core_run   = busy;
    core_start = en && ((state == STOP) || boundary);
  end

  // Handshake: reject illegal ratios, apply legal ones at once when stopped,
  // otherwise hold them until the next period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_act  <= DIV_W'(DIV_RST);
      div_pend <= '0;
      pend     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= xfer && !legal;
      if (pend && period_end) begin
        div_act <= div_pend;
        pend    <= 1'b0;
      end else if (xfer && legal) begin
        if (busy) begin
          div_pend <= cfg_div;
          pend     <= 1'b1;
        end else begin
          div_act  <= cfg_div;
        end
      end
    end
  end

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .n        (div_act),
    .run      (core_run),
    .start    (core_start),
    .boundary (boundary),
    .clko     (clko),
    .tick     (tick)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl (DIV_W=8, DIV_RST=4).
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clko;
  logic       tick;
  logic       busy;

  int total = 0;
  int bad   = 0;

`ifdef CLK_DIV_ODD_EN
  localparam logic [7:0] ODD_PROBE = 8'd1;
  localparam logic [7:0] STOP_DIV  = 8'd5;
`else
  localparam logic [7:0] ODD_PROBE = 8'd5;
  localparam logic [7:0] STOP_DIV  = 8'd2;
`endif

  clk_div_ctrl #(
    .DIV_W   (8),
    .DIV_RST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clko      (clko),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step len cycles, comparing clko and tick to MSB-first patterns.
  task automatic run_pat(input string tag, input logic [31:0] cpat,
                         input logic [31:0] tpat, input int len);
    for (int i = 0; i < len; i++) begin
      step();
      check({tag, "_clko"}, clko, cpat[len-1-i]);
      check({tag, "_tick"}, tick, tpat[len-1-i]);
    end
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    #2 rst = 1'b1;
    #1;
    check("rst_clko", clko, 1'b0);
    check("rst_tick", tick, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_err", cfg_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    step();
    step();
    rst = 1'b0;
    en  = 1'b1;

    // Default ratio 4: 1100 repeating, tick every 4 cycles.
    run_pat("n4", 32'b110011001100, 32'b100010001000, 12);
    check("n4_busy", busy, 1'b1);

    // Ratio change to 6 offered mid-period.
    run_pat("n4b", 32'b1, 32'b1, 1);
    check("chg_ready_pre", cfg_ready, 1'b1);
    cfg_valid = 1'b1;
    cfg_div   = 8'd6;
    step();
    cfg_valid = 1'b0;
    check("chg_clko", clko, 1'b1);
    check("chg_ready_low", cfg_ready, 1'b0);
    run_pat("chg_tail", 32'b00, 32'b00, 2);
    check("chg_ready_hold", cfg_ready, 1'b0);
    run_pat("n6_start", 32'b1, 32'b1, 1);
    check("chg_ready_back", cfg_ready, 1'b1);
    run_pat("n6", 32'b11000111000, 32'b00000100000, 11);

    // Illegal ratios: error pulse each time, N=6 pattern undisturbed.
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    step();
    check("ill1_err", cfg_err, 1'b1);
    check("ill1_clko", clko, 1'b1);
    check("ill1_tick", tick, 1'b1);
    cfg_div = 8'd0;
    step();
    check("ill0_err", cfg_err, 1'b1);
    check("ill0_clko", clko, 1'b1);
    cfg_div = ODD_PROBE;
    step();
    check("ill_odd_err", cfg_err, 1'b1);
    check("ill_odd_clko", clko, 1'b1);
    check("ill_ready", cfg_ready, 1'b1);
    cfg_valid = 1'b0;
    step();
    check("ill_err_clear", cfg_err, 1'b0);
    check("ill_clko", clko, 1'b0);
    run_pat("n6_after", 32'b00111000, 32'b00100000, 8);

    // Transfer of 8 on the boundary edge itself: applies one period later.
    cfg_valid = 1'b1;
    cfg_div   = 8'd8;
    step();
    cfg_valid = 1'b0;
    check("bnd_clko", clko, 1'b1);
    check("bnd_tick", tick, 1'b1);
    check("bnd_ready", cfg_ready, 1'b0);
    run_pat("bnd_n6", 32'b11000, 32'b00000, 5);
    check("bnd_ready_hold", cfg_ready, 1'b0);
    run_pat("n8_start", 32'b11, 32'b10, 2);
    check("n8_ready", cfg_ready, 1'b1);

    // Drop en one cycle after tick: period completes 11110000, then stop.
    en = 1'b0;
    run_pat("drain", 32'b110000, 32'b000000, 6);
    check("drain_busy", busy, 1'b1);
    step();
    check("stop_clko", clko, 1'b0);
    check("stop_tick", tick, 1'b0);
    check("stop_busy", busy, 1'b0);
    run_pat("stopped", 32'b00, 32'b00, 2);

    // Restart, drop en, re-assert during DRAIN: no gap between periods.
    en = 1'b1;
    run_pat("restart", 32'b11, 32'b10, 2);
    check("restart_busy", busy, 1'b1);
    en = 1'b0;
    run_pat("redrain", 32'b11, 32'b00, 2);
    en = 1'b1;
    run_pat("resume", 32'b000011110, 32'b000010000, 9);

    // Async reset in the high phase with a ratio pending.
    run_pat("pre_rst", 32'b0001, 32'b0001, 4);
    cfg_valid = 1'b1;
    cfg_div   = 8'd10;
    step();
    cfg_valid = 1'b0;
    check("pend_ready", cfg_ready, 1'b0);
    check("pend_clko", clko, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_clko", clko, 1'b0);
    check("arst_tick", tick, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", cfg_ready, 1'b1);
    check("arst_err", cfg_err, 1'b0);
    step();
    rst = 1'b0;
    run_pat("post_rst", 32'b11001100, 32'b10001000, 8);

    // Stop, load a ratio while stopped, then run at that ratio.
    en = 1'b0;
    begin
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 10) begin
        step();
        k++;
      end
    end
    check("stop_reached", busy, 1'b0);
    cfg_valid = 1'b1;
    cfg_div   = STOP_DIV;
    step();
    cfg_valid = 1'b0;
    check("stopcfg_ready", cfg_ready, 1'b1);
    check("stopcfg_err", cfg_err, 1'b0);
    en = 1'b1;
`ifdef CLK_DIV_ODD_EN
    run_pat("n5", 32'b1100011000, 32'b1000010000, 10);
`else
    run_pat("n2", 32'b101010, 32'b101010, 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
